// File: rtl/char_window_search.sv
// Sliding STR_LEN-byte window search over a buffered payload, hashed by an external md5 core.
// Define CHAR_WINDOW_HASH_CNT_EN to add the hash_count output (md5_start pulses per job).
module char_window_search #(
    parameter int BUF_DEPTH = 4096,
    parameter int STR_LEN   = 19
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 proc_start,
    input  logic [15:0]          proc_num_bytes,
    input  logic [7:0]           proc_data,
    input  logic                 proc_data_valid,
    input  logic [127:0]         proc_target_hash,
    input  logic                 proc_match_char_next,
    output logic                 proc_done,
    output logic                 proc_match,
    output logic [15:0]          proc_byte_pos,
    output logic [7:0]           proc_match_char,
    output logic [8*STR_LEN-1:0] md5_msg,
    output logic                 md5_start,
    input  logic                 md5_done,
    input  logic [127:0]         md5_hash
`ifdef CHAR_WINDOW_HASH_CNT_EN
    ,
    output logic [31:0]          hash_count
`endif
);

    localparam int AW = $clog2(BUF_DEPTH);
    localparam int WW = 8 * STR_LEN;
    localparam int CW = $clog2(STR_LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FILL, S_LOAD, S_HASH, S_WAIT, S_CMP, S_ADV, S_DONE
    } state_t;

    logic [7:0]    mem [BUF_DEPTH];
    logic [15:0]   wr_ptr_q;
    logic [7:0]    rd_data_q;
    logic [AW-1:0] rd_addr_d;
    logic [AW-1:0] wr_addr_d;
    logic          wr_room;

    state_t        state_q;
    logic [15:0]   pos_q;
    logic [15:0]   len_q;
    logic [CW-1:0] cnt_q;
    logic [WW-1:0] window_q;
    logic [127:0]  digest_q;
    logic [WW-1:0] md5_msg_q;
    logic          md5_start_q;
    logic          done_q;
    logic          match_q;
    logic [15:0]   byte_pos_q;
    logic [15:0]   last_w;
    logic [16:0]   need_w;
    logic          byte_ready;
`ifdef CHAR_WINDOW_HASH_CNT_EN
    logic [31:0]   hash_cnt_q;
`endif

    // Write side runs regardless of FSM state so payload can stream in while windows are hashed.
    assign wr_room   = {1'b0, wr_ptr_q} < 17'(BUF_DEPTH);
    assign wr_addr_d = proc_start ? '0 : wr_ptr_q[AW-1:0];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
        end else if (proc_start) begin
            wr_ptr_q <= proc_data_valid ? 16'd1 : 16'd0;
        end else if (proc_data_valid && wr_room) begin
            wr_ptr_q <= wr_ptr_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (proc_data_valid && (proc_start || wr_room)) begin
            mem[wr_addr_d] <= proc_data;
        end
        rd_data_q <= mem[rd_addr_d];
    end

    assign last_w     = len_q - 16'(STR_LEN);
    assign need_w     = {1'b0, pos_q} + 17'(STR_LEN);
    assign byte_ready = {1'b0, wr_ptr_q} > need_w;

    always_comb begin
        rd_addr_d = pos_q[AW-1:0] + AW'(STR_LEN);
        if (state_q == S_LOAD) begin
            rd_addr_d = AW'(cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            pos_q       <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            window_q    <= '0;
            digest_q    <= '0;
            md5_msg_q   <= '0;
            md5_start_q <= 1'b0;
            done_q      <= 1'b0;
            match_q     <= 1'b0;
            byte_pos_q  <= '0;
`ifdef CHAR_WINDOW_HASH_CNT_EN
            hash_cnt_q  <= '0;
`endif
        end else begin
            md5_start_q <= 1'b0;
            if (proc_start) begin
                state_q    <= S_FILL;
                done_q     <= 1'b0;
                match_q    <= 1'b0;
                byte_pos_q <= '0;
                pos_q      <= '0;
                cnt_q      <= '0;
                len_q      <= ({1'b0, proc_num_bytes} > 17'(BUF_DEPTH)) ? 16'(BUF_DEPTH)
                                                                        : proc_num_bytes;
`ifdef CHAR_WINDOW_HASH_CNT_EN
                hash_cnt_q <= '0;
`endif
            end else begin
                case (state_q)
                    S_IDLE: ;
                    S_FILL: begin
                        if (len_q < 16'(STR_LEN)) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else if (wr_ptr_q >= 16'(STR_LEN)) begin
                            cnt_q   <= '0;
                            state_q <= S_LOAD;
                        end
                    end
                    // cnt_q issues address k while the byte read on the previous cycle shifts in
                    S_LOAD: begin
                        if (cnt_q != '0) begin
                            window_q <= {window_q[WW-9:0], rd_data_q};
                        end
                        if (cnt_q == CW'(STR_LEN)) begin
                            state_q <= S_HASH;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    S_HASH: begin
                        md5_msg_q   <= window_q;
                        md5_start_q <= 1'b1;
                        state_q     <= S_WAIT;
`ifdef CHAR_WINDOW_HASH_CNT_EN
                        if (hash_cnt_q != '1) begin
                            hash_cnt_q <= hash_cnt_q + 32'd1;
                        end
`endif
                    end
                    S_WAIT: begin
                        if (md5_done) begin
                            digest_q <= md5_hash;
                            state_q  <= S_CMP;
                        end
                    end
                    S_CMP: begin
                        if (digest_q == proc_target_hash) begin
                            byte_pos_q <= pos_q;
                            match_q    <= 1'b1;
                            done_q     <= 1'b1;
                            state_q    <= S_DONE;
                        end else if (pos_q == last_w) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            cnt_q   <= '0;
                            state_q <= S_ADV;
                        end
                    end
                    S_ADV: begin
                        if (cnt_q == '0) begin
                            if (byte_ready) begin
                                cnt_q <= CW'(1);
                            end
                        end else begin
                            window_q <= {window_q[WW-9:0], rd_data_q};
                            pos_q    <= pos_q + 16'd1;
                            state_q  <= S_HASH;
                        end
                    end
                    S_DONE: begin
                        if (match_q && proc_match_char_next) begin
                            window_q <= {window_q[WW-9:0], window_q[WW-1 -: 8]};
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign proc_done       = done_q;
    assign proc_match      = match_q;
    assign proc_byte_pos   = byte_pos_q;
    assign proc_match_char = match_q ? window_q[WW-1 -: 8] : 8'd0;
    assign md5_msg         = md5_msg_q;
    assign md5_start       = md5_start_q;
`ifdef CHAR_WINDOW_HASH_CNT_EN
    assign hash_count      = hash_cnt_q;
`endif

endmodule

// File: tb/tb_char_window_search.sv
// Randomized bench for char_window_search: stub md5 (XOR fold) plus a window-search reference model.
module tb_char_window_search;

    localparam int STR_LEN = 19;
    localparam int WW      = 8 * STR_LEN;
    localparam int MAXB    = 64;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           proc_start;
    logic [15:0]    proc_num_bytes;
    logic [7:0]     proc_data;
    logic           proc_data_valid;
    logic [127:0]   proc_target_hash;
    logic           proc_match_char_next;
    logic           proc_done;
    logic           proc_match;
    logic [15:0]    proc_byte_pos;
    logic [7:0]     proc_match_char;
    logic [WW-1:0]  md5_msg;
    logic           md5_start;
    logic           md5_done = 1'b0;
    logic [127:0]   md5_hash = '0;
`ifdef CHAR_WINDOW_HASH_CNT_EN
    logic [31:0]    hash_count;
`endif

    always #5 clk = ~clk;

    char_window_search #(.BUF_DEPTH(4096), .STR_LEN(STR_LEN)) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .proc_start          (proc_start),
        .proc_num_bytes      (proc_num_bytes),
        .proc_data           (proc_data),
        .proc_data_valid     (proc_data_valid),
        .proc_target_hash    (proc_target_hash),
        .proc_match_char_next(proc_match_char_next),
        .proc_done           (proc_done),
        .proc_match          (proc_match),
        .proc_byte_pos       (proc_byte_pos),
        .proc_match_char     (proc_match_char),
        .md5_msg             (md5_msg),
        .md5_start           (md5_start),
        .md5_done            (md5_done),
        .md5_hash            (md5_hash)
`ifdef CHAR_WINDOW_HASH_CNT_EN
        ,
        .hash_count          (hash_count)
`endif
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state
    logic [7:0] pay [MAXB];
    int  wcyc [MAXB];
    int  m_len, m_nwin, m_pos;
    bit  m_match;

    // Observation state
    int  n_chk = 0, n_fail = 0;
    bit  chk_en = 0;
    bit  done_seen;
    int  seen_starts, done_cyc, start_cyc, mc_cnt;
    int  md5_lat = 5;

    function automatic logic [127:0] fold(input logic [WW-1:0] m);
        return m[127:0] ^ {104'd0, m[WW-1:128]};
    endfunction

    function automatic logic [WW-1:0] win_at(input int p);
        logic [WW-1:0] w = '0;
        for (int i = 0; i < STR_LEN; i++) w = {w[WW-9:0], pay[p+i]};
        return w;
    endfunction

    // Stub md5 core: XOR fold of the message after md5_lat cycles
    int cd = 0;
    logic [WW-1:0] cap = '0;
    always @(posedge clk) begin
        #1;
        md5_done = 1'b0;
        if (cd > 0) begin
            cd = cd - 1;
            if (cd == 0) begin
                md5_done = 1'b1;
                md5_hash = fold(cap);
            end
        end
        if (md5_start) begin
            cap = md5_msg;
            cd  = md5_lat;
        end
    end

    task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_job(input logic [127:0] tgt);
        m_match = 0; m_pos = 0; m_nwin = 0;
        if (m_len >= STR_LEN) begin
            for (int p = 0; p <= m_len - STR_LEN; p++) begin
                m_nwin++;
                if (fold(win_at(p)) == tgt) begin
                    m_match = 1; m_pos = p;
                    break;
                end
            end
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            if (chk_en) begin
                if (md5_start) begin
                    if (seen_starts < m_nwin) chk("md5_msg", md5_msg, win_at(seen_starts));
                    else chk("md5_start_count", WW'(seen_starts + 1), WW'(m_nwin));
                    seen_starts++;
                end
                if (proc_done) begin
                    if (!done_seen) begin
                        done_seen = 1; done_cyc = cyc;
                        chk("proc_match", WW'(proc_match), WW'(m_match));
                        chk("proc_byte_pos", WW'(proc_byte_pos), WW'(m_pos));
                        chk("starts_at_done", WW'(seen_starts), WW'(m_nwin));
`ifdef CHAR_WINDOW_HASH_CNT_EN
                        chk("hash_count", WW'(hash_count), WW'(m_nwin));
`endif
                    end
                    chk("match_char", WW'(proc_match_char),
                        WW'(m_match ? pay[m_pos + (mc_cnt % STR_LEN)] : 8'd0));
                    if (proc_match_char_next) mc_cnt++;
                end else begin
                    chk("match_busy", WW'(proc_match), WW'(0));
                    chk("char_busy", WW'(proc_match_char), WW'(0));
                end
            end
        end
    endtask

    task automatic start_job(input int len, input int gap, input int lat, input bit first_same,
                             input int tpos);
        int k = 0;
        logic [127:0] tgt;
        chk_en = 0;
        m_len = len;
        for (int i = 0; i < MAXB; i++) begin pay[i] = 8'($urandom); wcyc[i] = 0; end
        tgt = (tpos >= 0) ? fold(win_at(tpos)) : {$urandom, $urandom, $urandom, $urandom};
        model_job(tgt);
        md5_lat = lat;
        @(posedge clk); #1;
        proc_target_hash = tgt;
        proc_start = 1; proc_num_bytes = 16'(len);
        if (first_same && len > 0) begin proc_data = pay[0]; proc_data_valid = 1; k = 1; end
        @(posedge clk); #1;
        start_cyc = cyc; wcyc[0] = cyc;
        proc_start = 0; proc_data_valid = 0;
        seen_starts = 0; done_seen = 0; mc_cnt = 0; chk_en = 1;
`ifdef CHAR_WINDOW_HASH_CNT_EN
        chk("hash_count_clear", WW'(hash_count), WW'(0));
`endif
        for (; k < len; k++) begin
            repeat (gap - 1) begin @(posedge clk); #1; end
            proc_data = pay[k]; proc_data_valid = 1;
            @(posedge clk); #1;
            proc_data_valid = 0; wcyc[k] = cyc;
        end
    endtask

    task automatic finish_job(input int npulse);
        int c = 0;
        while (!done_seen && c < 4000) begin @(posedge clk); #1; c++; end
        chk("proc_done_timeout", WW'(done_seen), WW'(1));
        for (int n = 0; n < npulse; n++) begin
            proc_match_char_next = 1;
            @(posedge clk); #1;
            proc_match_char_next = 0;
            if ($urandom_range(1) == 1) begin @(posedge clk); #1; end
        end
        repeat (3) begin @(posedge clk); #1; end
        chk("md5_start_total", WW'(seen_starts), WW'(m_nwin));
        $display("job len=%0d match=%0b pos=%0d windows=%0d pulses=%0d done_cyc=%0d",
                 m_len, proc_match, proc_byte_pos, seen_starts, npulse, done_cyc);
    endtask

    task automatic wait_new_start();
        int s0 = seen_starts;
        int c = 0;
        while (seen_starts == s0 && c < 500) begin @(posedge clk); #1; c++; end
        chk("md5_start_timeout", WW'(seen_starts > s0), WW'(1));
    endtask

    initial begin
        int len, tpos;
        fork compare_loop(); join_none
        reset_n = 0; proc_start = 0; proc_num_bytes = '0; proc_data = '0; proc_data_valid = 0;
        proc_target_hash = '0; proc_match_char_next = 0;
        repeat (3) @(posedge clk); #1;
        chk("rst_done", WW'(proc_done), WW'(0));
        chk("rst_match", WW'(proc_match), WW'(0));
        chk("rst_pos", WW'(proc_byte_pos), WW'(0));
        chk("rst_char", WW'(proc_match_char), WW'(0));
        chk("rst_md5_start", WW'(md5_start), WW'(0));
        chk("rst_md5_msg", md5_msg, WW'(0));
        reset_n = 1;

        // Match at byte 3 of a 40-byte payload; 19 pulses walk bytes 3..21, 3 more wrap
        start_job(40, 1, 5, 0, 3);
        finish_job(22);
        chk("t1_pos", WW'(proc_byte_pos), WW'(3));
        chk("t1_match", WW'(proc_match), WW'(1));
        chk("t1_windows", WW'(seen_starts), WW'(4));

        // No match over 40 bytes: 22 windows
        start_job(40, 1, 5, 1, -1);
        finish_job(3);
        chk("t2_windows", WW'(seen_starts), WW'(22));
        chk("t2_match", WW'(proc_match), WW'(0));
        chk("t2_pos", WW'(proc_byte_pos), WW'(0));
`ifdef CHAR_WINDOW_HASH_CNT_EN
        chk("t2_hash_count", WW'(hash_count), WW'(22));
`endif

        // Short payload
        start_job(10, 1, 5, 0, -1);
        finish_job(2);
        chk("t3_latency_ok", WW'((done_cyc - start_cyc) <= 3), WW'(1));
        chk("t3_windows", WW'(seen_starts), WW'(0));

        // Exactly STR_LEN bytes: one window, with and without match
        start_job(STR_LEN, 2, 3, 1, 0);
        finish_job(STR_LEN + 1);
        chk("t4_windows", WW'(seen_starts), WW'(1));
        start_job(STR_LEN, 1, 3, 0, -1);
        finish_job(0);
        chk("t4b_windows", WW'(seen_starts), WW'(1));

        // Slow byte arrival: window search stalls until each byte lands
        start_job(40, 50, 2, 0, 0);
        finish_job(5);
        chk("t5_after_b18", WW'(done_cyc > wcyc[18]), WW'(1));
        start_job(40, 30, 2, 0, 6);
        finish_job(5);
        chk("t5b_after_b24", WW'(done_cyc > wcyc[24]), WW'(1));
        chk("t5b_pos", WW'(proc_byte_pos), WW'(6));

        // Restart while waiting on md5: stale digest must be ignored
        start_job(40, 1, 5, 0, -1);
        wait_new_start();
        repeat (2) begin @(posedge clk); #1; end
        start_job(40, 1, 5, 0, 10);
        finish_job(STR_LEN);
        chk("t6_pos", WW'(proc_byte_pos), WW'(10));

        // Reset mid-job
        start_job(40, 1, 3, 0, -1);
        wait_new_start();
        chk_en = 0;
        reset_n = 0;
        @(posedge clk); #1;
        chk("t7_done", WW'(proc_done), WW'(0));
        chk("t7_match", WW'(proc_match), WW'(0));
        chk("t7_pos", WW'(proc_byte_pos), WW'(0));
        chk("t7_md5_start", WW'(md5_start), WW'(0));
        chk("t7_md5_msg", md5_msg, WW'(0));
`ifdef CHAR_WINDOW_HASH_CNT_EN
        chk("t7_hash_count", WW'(hash_count), WW'(0));
`endif
        reset_n = 1;
        repeat (8) begin @(posedge clk); #1; end

        // Randomized jobs
        for (int j = 0; j < 12; j++) begin
            len  = int'($urandom_range(5, 60));
            tpos = (len >= STR_LEN && $urandom_range(1) == 1) ? int'($urandom_range(0, len - STR_LEN)) : -1;
            start_job(len, int'($urandom_range(1, 3)), int'($urandom_range(1, 7)),
                      1'($urandom_range(1)), tpos);
            finish_job(int'($urandom_range(0, 25)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
